// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Provides the word width, the widest possible word index and the write-buffer entry type.
// No ports; imported by dmem_wbuf and dmem_responder.
package dmem_pkg;

  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 32;
  // The widest word index a byte address can carry. Entries keep the index
  // zero-extended to this width so the struct does not depend on RAM size.
  localparam int IDX_MAX_W = ADDR_W - 2;

  localparam int DEF_DEPTH_WORDS = 64;
  localparam int DEF_WBUF_DEPTH  = 4;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic [WORD_W-1:0]    data;
  } wbuf_entry_t;

  // Mask selecting the low idx_w bits of a word index (address wrap).
  function automatic logic [IDX_MAX_W-1:0] idx_mask(input int idx_w);
    return IDX_MAX_W'((64'd1 << idx_w) - 64'd1);
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: circular posted-write buffer; drains its head every cycle it is non-empty.
// Ports: push/push_entry (tail insert), drain/drain_entry (head leaving this cycle),
//   look_idx -> match_vec (per-slot live match), hit/hit_data (youngest match), full, empty.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_WBUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  wbuf_entry_t          push_entry,
  input  logic [IDX_MAX_W-1:0] look_idx,
  output logic                 full,
  output logic                 empty,
  output logic                 drain,
  output wbuf_entry_t          drain_entry,
  output logic [DEPTH-1:0]     match_vec,
  output logic                 hit,
  output logic [WORD_W-1:0]    hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t        slots [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               pop;

  // The head is committed whenever anything is buffered; there is no RAM-side
  // backpressure, so the buffer only fills when stores arrive faster than one per cycle.
  assign pop         = (count != '0);
  assign drain       = pop;
  assign drain_entry = slots[head];
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset: validity is defined by head/count alone.
  always_ff @(posedge clk) begin
    if (push) slots[tail] <= push_entry;
  end

  // A slot is live when its distance from the head is below the count.
  // The head itself is still live in the cycle it drains, so a load in that
  // cycle sees it even though the RAM write has not landed yet.
  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    logic [PTR_W-1:0] age;
    assign age          = PTR_W'(s) - head;
    assign match_vec[s] = ({1'b0, age} < count) && (slots[s].idx == look_idx);
  end

  // Walk from oldest to youngest; the last match seen is the youngest store.
  always_comb begin
    logic [PTR_W-1:0] slot;
    hit      = 1'b0;
    hit_data = '0;
    slot     = head;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (match_vec[slot]) begin
        hit      = 1'b1;
        hit_data = slots[slot].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: core data port -> posted write buffer -> word RAM, with registered loads.
// Ports: clk, reset (async active-low), memwrite/memread/dataadr/writedata (request),
//   stall (request held), readdata/rvalid (load return one cycle after accept), idle (buffer empty).
// Build option DMEM_FWD_EN: loads forward from buffered stores; otherwise loads to a
//   buffered address stall until that store has reached the RAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WBUF_DEPTH  = DEF_WBUF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        stall,
  output logic [31:0] readdata,
  output logic        rvalid,
  output logic        idle
);

  localparam int                   IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [IDX_MAX_W-1:0] IDX_MASK = idx_mask(IDX_W);

  logic [WORD_W-1:0]    ram [DEPTH_WORDS];

  logic [IDX_MAX_W-1:0] idx;
  logic                 store_acc;
  logic                 load_acc;
  logic [WORD_W-1:0]    load_data;

  logic                 wb_full;
  logic                 wb_empty;
  logic                 wb_drain;
  wbuf_entry_t          wb_drain_entry;
  wbuf_entry_t          wb_push_entry;
  logic [WBUF_DEPTH-1:0] wb_match;
  logic                 wb_hit;
  logic [WORD_W-1:0]    wb_hit_data;

  // Byte offset and bits above the RAM index are dropped, so addresses wrap.
  assign idx = dataadr[ADDR_W-1:2] & IDX_MASK;

  assign wb_push_entry.idx  = idx;
  assign wb_push_entry.data = writedata;

  dmem_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .push        (store_acc),
    .push_entry  (wb_push_entry),
    .look_idx    (idx),
    .full        (wb_full),
    .empty       (wb_empty),
    .drain       (wb_drain),
    .drain_entry (wb_drain_entry),
    .match_vec   (wb_match),
    .hit         (wb_hit),
    .hit_data    (wb_hit_data)
  );

`ifdef DMEM_FWD_EN
  // Full is judged on the registered count only: a pop in this cycle does not
  // free a slot for a push in the same cycle.
  assign stall     = wb_full;
  assign load_data = wb_hit ? wb_hit_data : ram[idx[IDX_W-1:0]];

  logic unused_cfg;
  assign unused_cfg = ^wb_match;
`else
  // Without forwarding, a load must wait until no buffered store targets its
  // word; the RAM then holds the youngest value. The check applies whenever
  // memread is high, even if a simultaneous store would win.
  assign stall     = wb_full | (memread & (|wb_match));
  assign load_data = ram[idx[IDX_W-1:0]];

  logic unused_cfg;
  assign unused_cfg = ^{wb_hit, wb_hit_data};
`endif

  // A store and load in the same cycle: the store wins and the load is dropped.
  assign store_acc = memwrite & ~stall;
  assign load_acc  = memread & ~memwrite & ~stall;

  assign idle = wb_empty;

  // RAM is not reset; content survives a reset of the buffer and read path.
  // The read below sees the pre-write value because this update is non-blocking.
  always_ff @(posedge clk) begin
    if (wb_drain) ram[wb_drain_entry.idx[IDX_W-1:0]] <= wb_drain_entry.data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid   <= 1'b0;
      readdata <= '0;
    end else begin
      rvalid <= load_acc;
      if (load_acc) readdata <= load_data;
    end
  end

  // Upper index bits of buffered entries are always zero after masking.
  logic unused_bits;
  assign unused_bits = ^{dataadr[1:0], wb_drain_entry.idx[IDX_MAX_W-1:IDX_W], unused_cfg};

endmodule
